// File: rtl/axi_slave_mem.sv
// rtl/axi_slave_mem.sv - single-beat AXI4-Lite slave RAM with independent read and write FSMs.
// Optional AXI_SLAVE_WAIT_EN adds WAIT_CYCLES of latency before RVALID and BVALID.
module axi_slave_mem #(
   parameter int unsigned DEPTH       = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ARADDR,
   input  logic        ARVALID,
   output logic        ARREADY,
   output logic [31:0] RDATA,
   output logic [1:0]  RRESP,
   output logic        RVALID,
   input  logic        RREADY,
   input  logic [31:0] AWADDR,
   input  logic        AWVALID,
   output logic        AWREADY,
   input  logic [31:0] WDATA,
   input  logic        WVALID,
   output logic        WREADY,
   output logic [1:0]  BRESP,
   output logic        BVALID,
   input  logic        BREADY
);

   localparam int unsigned IW     = $clog2(DEPTH);
   localparam logic [1:0]  OKAY   = 2'b00;
   localparam logic [1:0]  SLVERR = 2'b10;
`ifdef AXI_SLAVE_WAIT_EN
   localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
`endif

   function automatic logic addr_ok(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE_ADDR;
      return (a >= BASE_ADDR) && (a[1:0] == 2'b00) && ((off >> 2) < DEPTH);
   endfunction

   function automatic logic [IW-1:0] addr_idx(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE_ADDR;
      return off[IW+1:2];
   endfunction

   logic [31:0] mem [DEPTH];

`ifdef AXI_SLAVE_WAIT_EN
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
   typedef enum logic [1:0] {W_COLLECT, W_COMMIT, W_DELAY, W_RESP} w_state_t;
   logic [CW-1:0] r_cnt, r_cnt_d, b_cnt, b_cnt_d;
`else
   typedef enum logic [0:0] {R_IDLE, R_RESP} r_state_t;
   typedef enum logic [1:0] {W_COLLECT, W_COMMIT, W_RESP} w_state_t;
`endif

   r_state_t r_state, r_next;
   logic     arready_d, rvalid_d, r_load;

   always_comb begin
      r_next    = r_state;
      arready_d = ARREADY;
      rvalid_d  = RVALID;
      r_load    = 1'b0;
`ifdef AXI_SLAVE_WAIT_EN
      r_cnt_d   = r_cnt;
`endif
      case (r_state)
         R_IDLE: begin
            arready_d = 1'b1;
            if (ARVALID && ARREADY) begin
               arready_d = 1'b0;
               r_load    = 1'b1;
`ifdef AXI_SLAVE_WAIT_EN
               if (WAIT_CYCLES != 0) begin
                  r_cnt_d = '0;
                  r_next  = R_WAIT;
               end else begin
                  rvalid_d = 1'b1;
                  r_next   = R_RESP;
               end
`else
               rvalid_d = 1'b1;
               r_next   = R_RESP;
`endif
            end
         end
`ifdef AXI_SLAVE_WAIT_EN
         R_WAIT: begin
            if (r_cnt == CW'(WAIT_CYCLES - 1)) begin
               rvalid_d = 1'b1;
               r_next   = R_RESP;
            end else begin
               r_cnt_d = r_cnt + 1'b1;
            end
         end
`endif
         R_RESP: begin
            if (RVALID && RREADY) begin
               rvalid_d  = 1'b0;
               arready_d = 1'b1;
               r_next    = R_IDLE;
            end
         end
         default: r_next = R_IDLE;
      endcase
   end

   // Data is captured at the AR handshake so a same-edge RAM write is not yet visible.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= R_IDLE;
         ARREADY <= 1'b0;
         RVALID  <= 1'b0;
         RDATA   <= '0;
         RRESP   <= OKAY;
`ifdef AXI_SLAVE_WAIT_EN
         r_cnt   <= '0;
`endif
      end else begin
         r_state <= r_next;
         ARREADY <= arready_d;
         RVALID  <= rvalid_d;
`ifdef AXI_SLAVE_WAIT_EN
         r_cnt   <= r_cnt_d;
`endif
         if (r_load) begin
            RDATA <= addr_ok(ARADDR) ? mem[addr_idx(ARADDR)] : '0;
            RRESP <= addr_ok(ARADDR) ? OKAY : SLVERR;
         end
      end
   end

   w_state_t    w_state, w_next;
   logic        aw_got, w_got, aw_got_d, w_got_d;
   logic        awready_d, wready_d, bvalid_d, aw_load, w_load, mem_we;
   logic [1:0]  bresp_d;
   logic [31:0] awaddr_q, wdata_q;

   always_comb begin
      w_next    = w_state;
      aw_got_d  = aw_got;
      w_got_d   = w_got;
      awready_d = AWREADY;
      wready_d  = WREADY;
      bvalid_d  = BVALID;
      bresp_d   = BRESP;
      aw_load   = 1'b0;
      w_load    = 1'b0;
      mem_we    = 1'b0;
`ifdef AXI_SLAVE_WAIT_EN
      b_cnt_d   = b_cnt;
`endif
      case (w_state)
         W_COLLECT: begin
            aw_load   = AWVALID && AWREADY;
            w_load    = WVALID && WREADY;
            aw_got_d  = aw_got || aw_load;
            w_got_d   = w_got || w_load;
            awready_d = !aw_got_d;
            wready_d  = !w_got_d;
            if (aw_got_d && w_got_d) w_next = W_COMMIT;
         end
         W_COMMIT: begin
            mem_we  = addr_ok(awaddr_q);
            bresp_d = addr_ok(awaddr_q) ? OKAY : SLVERR;
`ifdef AXI_SLAVE_WAIT_EN
            if (WAIT_CYCLES != 0) begin
               b_cnt_d = '0;
               w_next  = W_DELAY;
            end else begin
               bvalid_d = 1'b1;
               w_next   = W_RESP;
            end
`else
            bvalid_d = 1'b1;
            w_next   = W_RESP;
`endif
         end
`ifdef AXI_SLAVE_WAIT_EN
         W_DELAY: begin
            if (b_cnt == CW'(WAIT_CYCLES - 1)) begin
               bvalid_d = 1'b1;
               w_next   = W_RESP;
            end else begin
               b_cnt_d = b_cnt + 1'b1;
            end
         end
`endif
         W_RESP: begin
            if (BVALID && BREADY) begin
               bvalid_d  = 1'b0;
               aw_got_d  = 1'b0;
               w_got_d   = 1'b0;
               awready_d = 1'b1;
               wready_d  = 1'b1;
               w_next    = W_COLLECT;
            end
         end
         default: w_next = W_COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         w_state  <= W_COLLECT;
         aw_got   <= 1'b0;
         w_got    <= 1'b0;
         AWREADY  <= 1'b0;
         WREADY   <= 1'b0;
         BVALID   <= 1'b0;
         BRESP    <= OKAY;
         awaddr_q <= '0;
         wdata_q  <= '0;
`ifdef AXI_SLAVE_WAIT_EN
         b_cnt    <= '0;
`endif
      end else begin
         w_state <= w_next;
         aw_got  <= aw_got_d;
         w_got   <= w_got_d;
         AWREADY <= awready_d;
         WREADY  <= wready_d;
         BVALID  <= bvalid_d;
         BRESP   <= bresp_d;
`ifdef AXI_SLAVE_WAIT_EN
         b_cnt   <= b_cnt_d;
`endif
         if (aw_load) awaddr_q <= AWADDR;
         if (w_load)  wdata_q  <= WDATA;
      end
   end

   // RAM has no reset; reset forces W_COLLECT, which already blocks mem_we.
   always_ff @(posedge clk) begin
      if (mem_we) mem[addr_idx(awaddr_q)] <= wdata_q;
   end

endmodule

// File: tb/tb_axi_slave_mem.sv
// tb/tb_axi_slave_mem.sv - self-checking bench for axi_slave_mem with a transaction-level memory model.
module tb_axi_slave_mem;

`ifdef AXI_SLAVE_WAIT_EN
   localparam int WAITC = 3;
`else
   localparam int WAITC = 0;
`endif
   localparam int          WPARAM = (WAITC == 0) ? 2 : WAITC;
   localparam int          DEPTH  = 2048;
   localparam logic [31:0] BASE   = 32'h0000_1000;
   localparam int          RLAT   = 1 + WAITC;
   localparam int          BLAT   = 2 + WAITC;

   logic        clk, reset;
   logic [31:0] ARADDR, RDATA, AWADDR, WDATA;
   logic        ARVALID, ARREADY, RVALID, RREADY;
   logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
   logic [1:0]  RRESP, BRESP;

   axi_slave_mem #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(WPARAM)) dut (
      .clk(clk), .reset(reset),
      .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
      .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic bit m_ok(input logic [31:0] a);
      return (a >= BASE) && (a[1:0] == 2'b00) && (((a - BASE) >> 2) < DEPTH);
   endfunction

   // Model: word-indexed memory, expected response queues, commit applied one edge after AW+W complete.
   typedef struct {logic [31:0] d; logic [1:0] r; bit known;} rexp_t;
   logic [31:0] mm [int];
   rexp_t       rq [$];
   logic [1:0]  bq [$];
   rexp_t       me;
   bit          r_wait, b_wait, prv_rv, prv_rhs, prv_bv, prv_bhs, m_aw, m_w, commit_pend;
   int          r_hs_cyc, b_hs_cyc;
   logic [31:0] prv_rd, m_awa, m_wd, pend_a, pend_d;
   logic [1:0]  prv_rr, prv_br;

   always @(negedge clk) begin
      if (!reset) begin
         rq.delete(); bq.delete();
         r_wait = 0; b_wait = 0; prv_rv = 0; prv_rhs = 0; prv_bv = 0; prv_bhs = 0;
         m_aw = 0; m_w = 0; commit_pend = 0;
      end else begin
         if (RVALID) begin
            if (r_wait) begin chk("r_latency", 64'(cyc - r_hs_cyc), 64'(RLAT)); r_wait = 0; end
            if (prv_rv && !prv_rhs) begin
               chk("r_stable_data", RDATA, prv_rd);
               chk("r_stable_resp", RRESP, prv_rr);
            end
            chk("ar_blocked", ARREADY, 0);
            if (RREADY) begin
               if (rq.size() == 0) chk("r_unexpected", 1, 0);
               else begin
                  me = rq.pop_front();
                  chk("r_resp", RRESP, me.r);
                  if (me.known) chk("r_data", RDATA, me.d);
               end
            end
         end else if (r_wait && (cyc - r_hs_cyc) >= RLAT) begin
            chk("r_timeout", 0, 1);
            r_wait = 0;
         end
         prv_rv = RVALID; prv_rhs = RVALID && RREADY; prv_rd = RDATA; prv_rr = RRESP;
         if (ARVALID && ARREADY) begin
            me.r     = m_ok(ARADDR) ? 2'b00 : 2'b10;
            me.known = !m_ok(ARADDR) || mm.exists(int'((ARADDR - BASE) >> 2));
            me.d     = (m_ok(ARADDR) && me.known) ? mm[int'((ARADDR - BASE) >> 2)] : 32'h0;
            rq.push_back(me);
            r_wait = 1; r_hs_cyc = cyc;
         end
         if (commit_pend) begin
            if (m_ok(pend_a)) mm[int'((pend_a - BASE) >> 2)] = pend_d;
            commit_pend = 0;
         end
         if (BVALID) begin
            if (b_wait) begin chk("b_latency", 64'(cyc - b_hs_cyc), 64'(BLAT)); b_wait = 0; end
            if (prv_bv && !prv_bhs) chk("b_stable_resp", BRESP, prv_br);
            chk("aw_w_blocked", {AWREADY, WREADY}, 0);
            if (BREADY) begin
               if (bq.size() == 0) chk("b_unexpected", 1, 0);
               else chk("b_resp", BRESP, bq.pop_front());
            end
         end else if (b_wait && (cyc - b_hs_cyc) >= BLAT) begin
            chk("b_timeout", 0, 1);
            b_wait = 0;
         end
         prv_bv = BVALID; prv_bhs = BVALID && BREADY; prv_br = BRESP;
         if (AWVALID && AWREADY) begin m_aw = 1; m_awa = AWADDR; end
         if (WVALID && WREADY) begin m_w = 1; m_wd = WDATA; end
         if (m_aw && m_w) begin
            commit_pend = 1; pend_a = m_awa; pend_d = m_wd;
            bq.push_back(m_ok(m_awa) ? 2'b00 : 2'b10);
            b_wait = 1; b_hs_cyc = cyc; m_aw = 0; m_w = 0;
         end
      end
   end

   // Called and returns at posedge+1.
   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input int aw_t, input int w_t,
                            input int hold, output logic [1:0] resp);
      bit aw_done = 0, w_done = 0, aw_hs, w_hs, got = 0;
      int t = 0;
      resp = 2'bxx;
      while (!(aw_done && w_done) && t < 40) begin
         if (t == aw_t) begin AWADDR = a; AWVALID = 1'b1; end
         if (t == w_t) begin WDATA = d; WVALID = 1'b1; end
         @(negedge clk);
         aw_hs = AWVALID && AWREADY;
         w_hs  = WVALID && WREADY;
         @(posedge clk); #1;
         if (aw_hs) begin AWVALID = 1'b0; aw_done = 1; end
         if (w_hs) begin WVALID = 1'b0; w_done = 1; end
         t++;
      end
      if (!(aw_done && w_done)) begin
         chk("w_accept_timeout", 0, 1);
         AWVALID = 1'b0; WVALID = 1'b0;
         return;
      end
      for (int n = 0; n < 40 && !got; n++) begin
         @(negedge clk);
         got = BVALID;
      end
      if (!got) begin chk("bvalid_timeout", 0, 1); @(posedge clk); #1; return; end
      @(posedge clk); #1;
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         chk("b_hold", {BVALID, AWREADY, WREADY}, 3'b100);
         @(posedge clk); #1;
      end
      BREADY = 1'b1;
      @(negedge clk);
      resp = BRESP;
      @(posedge clk); #1;
      BREADY = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r, output int lat);
      int hs = 0;
      bit got = 0;
      d = 'x; r = 'x; lat = -1;
      ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1;
      for (int n = 0; n < 40 && !got; n++) begin
         @(negedge clk);
         if (ARREADY) begin got = 1; hs = cyc; end
      end
      @(posedge clk); #1;
      ARVALID = 1'b0;
      if (!got) begin chk("ar_timeout", 0, 1); RREADY = 1'b0; return; end
      got = 0;
      for (int n = 0; n < 40 && !got; n++) begin
         @(negedge clk);
         if (RVALID) begin got = 1; d = RDATA; r = RRESP; lat = cyc - hs; end
      end
      if (!got) chk("rvalid_timeout", 0, 1);
      @(posedge clk); #1;
      RREADY = 1'b0;
   endtask

   logic [31:0] rd, rd_col;
   logic [1:0]  rr, br, br_col, rr_col;
   int          lat, lat_col;
   logic [31:0] src [4] = '{32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'h99AABBCC};

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      ARADDR = '0; ARVALID = 0; RREADY = 0; AWADDR = '0; AWVALID = 0; WDATA = '0; WVALID = 0; BREADY = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_outputs", {ARREADY, RVALID, AWREADY, WREADY, BVALID, RRESP, BRESP}, 0);
      chk("rst_rdata", RDATA, 0);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_reset", {ARREADY, AWREADY, WREADY}, 3'b111);

      axi_write(32'h1000, 32'hAABBCCDD, 0, 0, 0, br);
      chk("w1000_bresp", br, 2'b00);
      axi_read(32'h1000, rd, rr, lat);
      chk("r1000_data", rd, 32'hAABBCCDD);
      chk("r1000_resp", rr, 2'b00);
      chk("r1000_latency", 64'(lat), 64'(RLAT));

      axi_write(32'h2000, 32'h11223344, 0, 2, 0, br);
      chk("aw_first_bresp", br, 2'b00);
      axi_read(32'h2000, rd, rr, lat);
      chk("r2000_data", rd, 32'h11223344);

      axi_write(32'h1004, 32'h11223344, 3, 0, 0, br);
      chk("w_first_bresp", br, 2'b00);
      axi_write(32'h1008, 32'h55667788, 0, 0, 5, br);
      chk("hold_bresp", br, 2'b00);
      axi_write(32'h100C, 32'h99AABBCC, 0, 1, 0, br);

      axi_read(32'h0FFC, rd, rr, lat);
      chk("below_base_resp", rr, 2'b10);
      chk("below_base_data", rd, 32'h0);
      axi_write(32'h1002, 32'hDEADBEEF, 0, 0, 0, br);
      chk("unaligned_bresp", br, 2'b10);
      axi_read(32'h1000, rd, rr, lat);
      chk("unaligned_no_write", rd, 32'hAABBCCDD);
      axi_write(32'h2FFC, 32'h12345678, 0, 0, 0, br);
      chk("top_word_bresp", br, 2'b00);
      axi_read(32'h2FFC, rd, rr, lat);
      chk("top_word_data", rd, 32'h12345678);
      axi_read(32'h3000, rd, rr, lat);
      chk("past_end_resp", rr, 2'b10);
      chk("past_end_data", rd, 32'h0);

      for (int i = 0; i < 4; i++) begin
         axi_read(32'h1000 + 32'(4 * i), rd, rr, lat);
         axi_write(32'h2000 + 32'(4 * i), rd, 0, 0, 0, br);
      end
      for (int i = 0; i < 4; i++) begin
         axi_read(32'h2000 + 32'(4 * i), rd, rr, lat);
         chk($sformatf("copy_dst%0d", i), rd, src[i]);
      end

      axi_write(32'h1010, 32'h01010101, 0, 0, 0, br);
      fork
         axi_write(32'h1010, 32'h02020202, 0, 0, 0, br_col);
         begin
            @(posedge clk); #1;
            axi_read(32'h1010, rd_col, rr_col, lat_col);
         end
      join
      chk("collision_old_data", rd_col, 32'h01010101);
      axi_read(32'h1010, rd, rr, lat);
      chk("collision_new_data", rd, 32'h02020202);

      AWADDR = 32'h1030; WDATA = 32'hCAFE0001; AWVALID = 1; WVALID = 1;
      @(posedge clk); #1;
      AWVALID = 0; WVALID = 0;
      begin
         bit got = 0;
         for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            got = BVALID;
         end
         chk("pre_reset_bvalid", got, 1);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("reset_drops_b", {BVALID, AWREADY, WREADY, ARREADY}, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      axi_write(32'h1034, 32'hCAFE0002, 0, 0, 0, br);
      chk("post_reset_bresp", br, 2'b00);
      axi_read(32'h1034, rd, rr, lat);
      chk("post_reset_data", rd, 32'hCAFE0002);
      axi_read(32'h1030, rd, rr, lat);
      chk("committed_before_reset", rd, 32'hCAFE0001);

      axi_write(32'h1040, 32'h0BADF00D, 0, 0, 0, br);
      AWADDR = 32'h1040; AWVALID = 1;
      @(posedge clk); #1;
      AWVALID = 0;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      WDATA = 32'hFFFFFFFF; WVALID = 1;
      @(posedge clk); #1;
      WVALID = 0;
      repeat (4) @(posedge clk);
      #1;
      chk("orphan_w_no_b", BVALID, 0);
      axi_read(32'h1040, rd, rr, lat);
      chk("dropped_aw_no_write", rd, 32'h0BADF00D);

      repeat (4) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
